// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master that streams n_tx bytes from a register file out on MOSI
// and writes each received MISO byte back through a second write port.
module spi_master_ctrl #(
    parameter int N       = 8,
    parameter int CLK_DIV = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [N-1:0]  i_n_tx,
    input  logic [7:0]    i_tx_data,
    input  logic          i_miso,
    output logic [N-1:0]  o_rd_addr,
    output logic          o_wr_en,
    output logic [N-1:0]  o_wr_addr,
    output logic [31:0]   o_wr_data,
    output logic          o_sclk,
    output logic          o_mosi,
    output logic          o_cs_n,
    output logic          o_busy,
    output logic          o_done
);
    localparam int CW = $clog2(CLK_DIV);

    typedef enum logic [2:0] {IDLE, LOAD, FETCH, SHIFT, STORE, FINISH} state_t;

    state_t         r_state;
    logic [N-1:0]   r_ntx;
    logic [N-1:0]   r_idx;
    logic [7:0]     r_sreg;
    logic [7:0]     r_rx;
    logic [CW-1:0]  r_div;
    logic [2:0]     r_bit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_ntx     <= '0;
            r_idx     <= '0;
            r_sreg    <= '0;
            r_rx      <= '0;
            r_div     <= '0;
            r_bit     <= '0;
            o_rd_addr <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_sclk    <= 1'b0;
            o_mosi    <= 1'b0;
            o_cs_n    <= 1'b1;
            o_done    <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            o_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (i_n_tx != '0) begin
                            r_ntx     <= i_n_tx;
                            r_idx     <= '0;
                            o_rd_addr <= '0;
                            o_cs_n    <= 1'b0;
                            r_state   <= LOAD;
                        end else begin
                            o_done  <= 1'b1;
                            r_state <= FINISH;
                        end
                    end
                end
                // rd_addr was set on entry; register file answers during FETCH
                LOAD: r_state <= FETCH;
                FETCH: begin
                    r_sreg  <= i_tx_data;
                    o_mosi  <= i_tx_data[7];
                    r_bit   <= '0;
                    r_div   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (r_div == CW'(CLK_DIV - 1)) begin
                        r_div <= '0;
                        if (!o_sclk) begin
                            o_sclk <= 1'b1;
                            r_rx   <= {r_rx[6:0], i_miso};
                        end else begin
                            o_sclk <= 1'b0;
                            if (r_bit == 3'd7) begin
                                o_wr_en   <= 1'b1;
                                o_wr_addr <= r_idx;
                                o_wr_data <= {24'b0, r_rx};
                                r_state   <= STORE;
                            end else begin
                                r_bit  <= r_bit + 3'd1;
                                r_sreg <= {r_sreg[6:0], 1'b0};
                                o_mosi <= r_sreg[6];
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                STORE: begin
                    if (r_idx == r_ntx - 1'b1) begin
                        o_cs_n  <= 1'b1;
                        o_done  <= 1'b1;
                        r_state <= FINISH;
                    end else begin
                        r_idx     <= r_idx + 1'b1;
                        o_rd_addr <= r_idx + 1'b1;
                        r_state   <= LOAD;
                    end
                end
                FINISH: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy = (r_state != IDLE);
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: register-file model, simple SPI slave
// (loopback or fixed byte) and a passive monitor that logs bus activity.
module tb_spi_master_ctrl;
    localparam int N = 8;
    localparam int CLK_DIV = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [N-1:0]  n_tx = '0;
    logic [7:0]    tx_data;
    logic          miso;
    logic [N-1:0]  rd_addr, wr_addr;
    logic          wr_en, sclk, mosi, cs_n, busy, done;
    logic [31:0]   wr_data;

    int checks = 0;
    int failures = 0;

    logic [7:0]    mem [0:255];
    logic          loopback = 1'b1;
    logic [7:0]    sbyte = 8'h00;
    logic [2:0]    sptr = 3'd7;

    int            wr_cnt = 0, done_cnt = 0, overlap = 0, cs_rises = 0, cs_low = 0, sclk_edges = 0;
    logic          sclk_q = 1'b0, cs_q = 1'b1;
    logic [7:0]    mosi_sh = 8'h00;
    logic [N-1:0]  wa_log [0:1023];
    logic [31:0]   wd_log [0:1023];

    always #5 clk = ~clk;

    spi_master_ctrl #(.N(N), .CLK_DIV(CLK_DIV)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_n_tx(n_tx),
        .i_tx_data(tx_data), .i_miso(miso), .o_rd_addr(rd_addr),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_sclk(sclk), .o_mosi(mosi), .o_cs_n(cs_n), .o_busy(busy), .o_done(done)
    );

    assign miso = loopback ? mosi : sbyte[sptr];

    always @(posedge clk) tx_data <= mem[rd_addr];

    always @(negedge clk) begin
        if (wr_en) begin
            wa_log[wr_cnt] <= wr_addr;
            wd_log[wr_cnt] <= wr_data;
            wr_cnt <= wr_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
        if (wr_en && done) overlap <= overlap + 1;
        if (cs_n && !cs_q) cs_rises <= cs_rises + 1;
        if (!cs_n) cs_low <= cs_low + 1;
        if (sclk != sclk_q) sclk_edges <= sclk_edges + 1;
        if (sclk && !sclk_q) mosi_sh <= {mosi_sh[6:0], mosi};
        if (cs_n) sptr <= 3'd7;
        else if (!sclk && sclk_q) sptr <= sptr - 3'd1;
        sclk_q <= sclk;
        cs_q <= cs_n;
    end

    task automatic kick(input logic [N-1:0] nt);
        @(negedge clk);
        start = 1'b1;
        n_tx = nt;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int max, input string name);
        int d0;
        bit ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_timeout got=no_done exp=done within %0d clks", name, max);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs_n, sclk, mosi, wr_en, busy, done} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctl got=%b exp=100000", {cs_n, sclk, mosi, wr_en, busy, done});
        end
        checks++;
        if ({wr_addr, wr_data, rd_addr} !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h/%h/%h exp=0", wr_addr, wr_data, rd_addr);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single;
        int w0, d0, cyc;
        mem[0] = 8'hA5;
        loopback = 1'b0;
        sbyte = 8'h3C;
        w0 = wr_cnt;
        d0 = done_cnt;
        kick(8'd1);
        // cs_n low from LOAD: LOAD + FETCH + 16*CLK_DIV SHIFT clocks before wr_en
        cyc = 1;
        while (!wr_en && cyc < 1000) begin
            @(negedge clk);
            if (!wr_en) cyc++;
        end
        wait_done(200, "single");
        checks++;
        if (cyc != 2 + 16 * CLK_DIV) begin
            failures++;
            $display("FAIL single_len got=%0d exp=%0d", cyc, 2 + 16 * CLK_DIV);
        end
        checks++;
        if (mosi_sh !== 8'hA5) begin
            failures++;
            $display("FAIL single_mosi got=%h exp=a5", mosi_sh);
        end
        checks++;
        if (wr_cnt - w0 != 1) begin
            failures++;
            $display("FAIL single_wrcnt got=%0d exp=1", wr_cnt - w0);
        end
        checks++;
        if (wa_log[w0] !== 8'h00 || wd_log[w0] !== 32'h0000_003C) begin
            failures++;
            $display("FAIL single_wr got=%h:%h exp=00:0000003c", wa_log[w0], wd_log[w0]);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL single_done got=%0d exp=1", done_cnt - d0);
        end
        loopback = 1'b1;
    endtask

    task automatic test_multi;
        int w0, d0, c0;
        mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03;
        w0 = wr_cnt; d0 = done_cnt; c0 = cs_rises;
        kick(8'd3);
        wait_done(400, "multi");
        checks++;
        if (wr_cnt - w0 != 3) begin
            failures++;
            $display("FAIL multi_wrcnt got=%0d exp=3", wr_cnt - w0);
        end
        checks++;
        if ({wa_log[w0], wa_log[w0+1], wa_log[w0+2]} !== 24'h000102 ||
            {wd_log[w0], wd_log[w0+1], wd_log[w0+2]} !== {32'h1, 32'h2, 32'h3}) begin
            failures++;
            $display("FAIL multi_wr got=%h %h %h/%h %h %h exp=00 01 02/1 2 3",
                     wa_log[w0], wa_log[w0+1], wa_log[w0+2], wd_log[w0], wd_log[w0+1], wd_log[w0+2]);
        end
        checks++;
        if (cs_rises - c0 != 1) begin
            failures++;
            $display("FAIL multi_cs got=%0d rises exp=1", cs_rises - c0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL multi_done got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_zero;
        int w0, d0, l0, s0;
        w0 = wr_cnt; d0 = done_cnt; l0 = cs_low; s0 = sclk_edges;
        kick(8'd0);
        wait_done(20, "zero");
        checks++;
        if (cs_low != l0 || sclk_edges != s0) begin
            failures++;
            $display("FAIL zero_bus got=cs_low%0d/sclk%0d exp=0/0", cs_low - l0, sclk_edges - s0);
        end
        checks++;
        if (wr_cnt != w0) begin
            failures++;
            $display("FAIL zero_wr got=%0d exp=0", wr_cnt - w0);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL zero_done got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back;
        int w0, d0;
        mem[0] = 8'h11; mem[1] = 8'h22;
        w0 = wr_cnt; d0 = done_cnt;
        kick(8'd2);
        repeat (10) @(negedge clk);
        kick(8'd5);
        wait_done(400, "busy");
        repeat (200) @(negedge clk);
        checks++;
        if (wr_cnt - w0 != 2) begin
            failures++;
            $display("FAIL busy_wrcnt got=%0d exp=2", wr_cnt - w0);
        end
        checks++;
        if (wd_log[w0] !== 32'h11 || wd_log[w0+1] !== 32'h22) begin
            failures++;
            $display("FAIL busy_data got=%h %h exp=11 22", wd_log[w0], wd_log[w0+1]);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL busy_done got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_async_reset;
        int w0, d0, s0, n;
        mem[0] = 8'h77; mem[1] = 8'h88;
        w0 = wr_cnt; d0 = done_cnt; s0 = sclk_edges;
        kick(8'd2);
        n = 0;
        while (sclk_edges - s0 < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sclk_edges - s0 < 3) begin
            failures++;
            $display("FAIL arst_edges got=%0d exp>=3", sclk_edges - s0);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cs_n, sclk, mosi, wr_en, busy, done} !== 6'b100000 ||
            {wr_addr, wr_data, rd_addr} !== '0) begin
            failures++;
            $display("FAIL arst_outs got=%b %h %h %h exp=100000 0 0 0",
                     {cs_n, sclk, mosi, wr_en, busy, done}, wr_addr, wr_data, rd_addr);
        end
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        checks++;
        if (wr_cnt != w0 || done_cnt != d0) begin
            failures++;
            $display("FAIL arst_abort got=wr%0d/done%0d exp=0/0", wr_cnt - w0, done_cnt - d0);
        end
        mem[0] = 8'h5E;
        kick(8'd1);
        wait_done(200, "arst_restart");
        checks++;
        if (wr_cnt - w0 != 1 || wd_log[w0] !== 32'h5E || wa_log[w0] !== 8'h00) begin
            failures++;
            $display("FAIL arst_restart got=%0d %h:%h exp=1 00:0000005e", wr_cnt - w0, wa_log[w0], wd_log[w0]);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL arst_done got=%0d exp=1", done_cnt - d0);
        end
    endtask

    task automatic test_boundary;
        int w0, d0, bad;
        logic [7:0] b;
        for (int i = 0; i < 255; i++) begin
            b = i[7:0];
            mem[i] = b ^ 8'h5A;
        end
        w0 = wr_cnt; d0 = done_cnt;
        kick(8'd255);
        wait_done(255 * 80 + 100, "bound");
        checks++;
        if (wr_cnt - w0 != 255) begin
            failures++;
            $display("FAIL bound_wrcnt got=%0d exp=255", wr_cnt - w0);
        end
        bad = 0;
        for (int i = 0; i < 255; i++) begin
            b = i[7:0];
            if (wa_log[w0+i] !== b || wd_log[w0+i] !== {24'b0, b ^ 8'h5A}) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bound_seq got=%0d bad entries exp=0", bad);
        end
        checks++;
        if (wa_log[w0+254] !== 8'hFE) begin
            failures++;
            $display("FAIL bound_last got=%h exp=fe", wa_log[w0+254]);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL bound_done got=%0d exp=1", done_cnt - d0);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset;
        test_single;
        test_multi;
        test_zero;
        test_back_to_back;
        test_async_reset;
        test_boundary;
        checks++;
        if (overlap != 0) begin
            failures++;
            $display("FAIL wr_done_overlap got=%0d exp=0", overlap);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
